// File: rtl/io_sequencer_if.sv
// Signal bundle between the instruction decoder/datapath and io_sequencer.
// The sequencer drives the slave modport; the surrounding datapath (or a bench) uses master.
interface io_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        opcode;
  logic              confirm_button;
  logic [DATA_W-1:0] switches;
  logic              pc_enable;
  logic              in_write_enable;
  logic [DATA_W-1:0] in_data;
  logic              out_write_enable;
  logic              halted;
  logic              waiting_input;
  logic [2:0]        state;

  // Strobes (pc_enable, in_write_enable, out_write_enable) are single-cycle qualifiers
  // sampled by the datapath on the rising clock; there is no back-pressure path.
  modport slave (
    input  opcode, confirm_button, switches,
    output pc_enable, in_write_enable, in_data, out_write_enable, halted, waiting_input, state
  );

  modport master (
    output opcode, confirm_button, switches,
    input  pc_enable, in_write_enable, in_data, out_write_enable, halted, waiting_input, state
  );
endinterface

// File: rtl/io_sequencer.sv
// Stall controller for IN/OUT/HALT: freezes the PC until a debounced button press,
// commits the synchronised switch value for IN, and strobes OUT for one cycle.
module io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int DATA_W          = 32
) (
  input  logic           clock,
  input  logic           reset,
  io_sequencer_if.slave  bus
);
  localparam logic [4:0] OP_IN   = 5'b01100;
  localparam logic [4:0] OP_OUT  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b00101;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    WAIT_IN   = 3'd1,
    COMMIT_IN = 3'd2,
    HALTED    = 3'd3,
    RESUME    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              btn_meta_q, btn_s_q;
  logic [DATA_W-1:0] sw_meta_q, sw_s_q;
  logic              deb_q, deb_dly_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] in_data_q;
  logic              press;
  logic              pc_en, in_we, out_we, capture;

  // Two-stage synchronisers for the asynchronous button and switch bank
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= bus.confirm_button;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= bus.switches;
      sw_s_q     <= sw_meta_q;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      deb_dly_q <= deb_q;
      if (btn_s_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= ~deb_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      in_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) in_data_q <= sw_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    in_we   = 1'b0;
    out_we  = 1'b0;
    capture = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.opcode == OP_IN) begin
          state_d = WAIT_IN;
        end else if (bus.opcode == OP_HALT) begin
          state_d = HALTED;
        end else begin
          pc_en  = 1'b1;
          out_we = (bus.opcode == OP_OUT);
        end
      end
      WAIT_IN: begin
        if (press) begin
          capture = 1'b1;
          state_d = COMMIT_IN;
        end
      end
      COMMIT_IN: begin
        in_we   = 1'b1;
        pc_en   = 1'b1;
        state_d = RUN;
      end
      HALTED: begin
        if (press) state_d = RESUME;
      end
      RESUME: begin
        pc_en   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Enables are gated by reset so nothing is written while reset is held
  assign bus.pc_enable        = pc_en & reset;
  assign bus.in_write_enable  = in_we & reset;
  assign bus.out_write_enable = out_we & reset;
  assign bus.in_data          = in_data_q;
  assign bus.halted           = (state_q == HALTED);
  assign bus.waiting_input    = (state_q == WAIT_IN);
  assign bus.state            = state_q;
endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer with DEBOUNCE_CYCLES=4: IN commit, glitch rejection,
// HALT/resume, OUT strobe, held button, back-to-back IN and mid-debounce reset.
module tb_io_sequencer;
  localparam int DATA_W = 32;
  localparam int DEB    = 4;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_IN   = 5'b01100;
  localparam logic [4:0] OP_OUT  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b00101;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  io_sequencer_if #(.DATA_W(DATA_W)) bus ();

  io_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16),
    .DATA_W(DATA_W)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the button and walk the 2+DEB edges before press; the state must not move early
  task automatic hold_until_press(input logic [2:0] wait_st);
    bus.confirm_button = 1'b1;
    for (int i = 1; i <= 2 + DEB; i++) begin
      step();
      check($sformatf("pre_press_state_%0d", i), {29'd0, bus.state}, {29'd0, wait_st});
      check($sformatf("pre_press_pc_%0d", i), {31'd0, bus.pc_enable}, 32'd0);
    end
  endtask

  task automatic release_button();
    bus.confirm_button = 1'b0;
    repeat (2 + DEB + 2) step();
  endtask

  // Edge after press in WAIT_IN: expect COMMIT_IN with the scoreboarded switch value
  task automatic check_commit(input string tag);
    step();
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_state"}, {29'd0, bus.state}, 32'd2);
    check({tag, "_iwe"}, {31'd0, bus.in_write_enable}, 32'd1);
    check({tag, "_pc"}, {31'd0, bus.pc_enable}, 32'd1);
    check({tag, "_data"}, bus.in_data, exp_v);
    bus.opcode = OP_ADD;
    step();
    check({tag, "_back_run"}, {29'd0, bus.state}, 32'd0);
    check({tag, "_iwe_off"}, {31'd0, bus.in_write_enable}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.opcode         = OP_ADD;
    bus.confirm_button = 1'b0;
    bus.switches       = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", {29'd0, bus.state}, 32'd0);
    check("reset_pc_forced", {31'd0, bus.pc_enable}, 32'd0);
    check("reset_in_data", bus.in_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: ordinary instructions advance the PC
    for (int i = 0; i < 5; i++) begin
      step();
      check("run_pc", {31'd0, bus.pc_enable}, 32'd1);
      check("run_iwe", {31'd0, bus.in_write_enable}, 32'd0);
      check("run_owe", {31'd0, bus.out_write_enable}, 32'd0);
      check("run_state", {29'd0, bus.state}, 32'd0);
    end

    // 2/3: IN with a 3-cycle glitch first, then a real press
    bus.opcode   = OP_IN;
    bus.switches = 32'h0000_00A5;
    #1;
    check("in_run_pc_stall", {31'd0, bus.pc_enable}, 32'd0);
    step();
    check("in_wait_state", {29'd0, bus.state}, 32'd1);
    check("in_waiting_flag", {31'd0, bus.waiting_input}, 32'd1);
    bus.confirm_button = 1'b1;
    repeat (3) step();
    bus.confirm_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch_state", {29'd0, bus.state}, 32'd1);
      check("glitch_pc", {31'd0, bus.pc_enable}, 32'd0);
    end
    exp_q.push_back(32'h0000_00A5);
    hold_until_press(3'd1);
    check_commit("in1");

    // Button still held: the next IN must wait for a fresh press
    bus.opcode   = OP_IN;
    bus.switches = 32'h5A5A_1234;
    step();
    repeat (20) step();
    check("held_no_press_state", {29'd0, bus.state}, 32'd1);
    check("held_old_data", bus.in_data, 32'h0000_00A5);
    bus.confirm_button = 1'b0;
    repeat (2 + DEB + 2) step();
    check("release_still_wait", {29'd0, bus.state}, 32'd1);
    exp_q.push_back(32'h5A5A_1234);
    hold_until_press(3'd1);
    check_commit("in2");
    release_button();
    check("data_held_after_commit", bus.in_data, 32'h5A5A_1234);

    // 4: HALT and resume
    bus.opcode = OP_HALT;
    #1;
    check("halt_run_pc_stall", {31'd0, bus.pc_enable}, 32'd0);
    step();
    for (int i = 0; i < 100; i++) begin
      check("halted_flag", {31'd0, bus.halted}, 32'd1);
      check("halted_pc", {31'd0, bus.pc_enable}, 32'd0);
      step();
    end
    hold_until_press(3'd3);
    step();
    check("resume_state", {29'd0, bus.state}, 32'd4);
    check("resume_pc", {31'd0, bus.pc_enable}, 32'd1);
    bus.opcode = OP_ADD;
    step();
    check("resume_back_run", {29'd0, bus.state}, 32'd0);
    check("resume_halted_off", {31'd0, bus.halted}, 32'd0);
    release_button();

    // 5: OUT strobe between ADDs
    check("pre_out_owe", {31'd0, bus.out_write_enable}, 32'd0);
    bus.opcode = OP_OUT;
    #1;
    check("out_owe", {31'd0, bus.out_write_enable}, 32'd1);
    check("out_pc", {31'd0, bus.pc_enable}, 32'd1);
    step();
    bus.opcode = OP_ADD;
    #1;
    check("post_out_owe", {31'd0, bus.out_write_enable}, 32'd0);
    check("post_out_pc", {31'd0, bus.pc_enable}, 32'd1);
    check("post_out_state", {29'd0, bus.state}, 32'd0);

    // 6: reset in WAIT_IN with debounce counter at 2
    bus.opcode   = OP_IN;
    bus.switches = 32'hCAFE_0001;
    step();
    check("rst_pre_wait", {29'd0, bus.state}, 32'd1);
    bus.confirm_button = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("rst_abort_state", {29'd0, bus.state}, 32'd0);
    check("rst_abort_pc", {31'd0, bus.pc_enable}, 32'd0);
    check("rst_abort_iwe", {31'd0, bus.in_write_enable}, 32'd0);
    check("rst_abort_owe", {31'd0, bus.out_write_enable}, 32'd0);
    check("rst_abort_data", bus.in_data, 32'd0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(32'hCAFE_0001);
    hold_until_press(3'd1);
    check_commit("in_after_rst");
    release_button();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
